// File: rtl/keccak_digest_serializer_pkg.sv
// rtl/keccak_digest_serializer_pkg.sv - shared constants and types for the keccak digest serializer
package keccak_digest_serializer_pkg;

    localparam int DIGEST_W = 512;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Word counter width; a single-word digest still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/keccak_digest_serializer_if.sv
// rtl/keccak_digest_serializer_if.sv - valid/ready word stream carrying the serialized digest
interface keccak_digest_serializer_if #(
    parameter int DW = 64
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/keccak_digest_serializer.sv
// rtl/keccak_digest_serializer.sv - captures a keccak digest on out_ready rise and streams it as DW-bit words
module keccak_digest_serializer
    import keccak_digest_serializer_pkg::*;
#(
    parameter int DW       = 64,
    parameter int OUT_BITS = 512
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGEST_W-1:0]       hash_in,
    input  logic                      hash_ready,
    keccak_digest_serializer_if.master m_if,
    output logic                      busy,
    output logic                      overrun,
    input  logic                      clr_ovr
);

    localparam int NWORDS = OUT_BITS / DW;
    localparam int CW     = cnt_width(NWORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

    if ((OUT_BITS % DW) != 0 || OUT_BITS > DIGEST_W || NWORDS < 1) begin : g_bad_params
        $error("keccak_digest_serializer: OUT_BITS must be a multiple of DW and <= DIGEST_W");
    end

    if (OUT_BITS < DIGEST_W) begin : g_trunc
        logic unused_hash;
        assign unused_hash = ^hash_in[DIGEST_W-1:OUT_BITS];
    end

    state_e              state_q, state_d;
    logic                hr_q;
    logic [OUT_BITS-1:0] buf_q, buf_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovr_q, ovr_d;

    logic rise;
    logic xfer;
    logic at_last;
    logic final_xfer;

    // hr_q resets high so a digest already presented across reset is not re-captured.
    assign rise       = hash_ready & ~hr_q;
    assign at_last    = (cnt_q == LAST_IDX);
    assign xfer       = (state_q == ST_SEND) & m_if.m_ready;
    assign final_xfer = xfer & at_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            hr_q    <= 1'b1;
            buf_q   <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hr_q    <= hash_ready;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_SEND;
                    buf_d   = hash_in[OUT_BITS-1:0];
                    cnt_d   = '0;
                end
            end
            ST_SEND: begin
                if (final_xfer) begin
                    cnt_d = '0;
                    if (rise) begin
                        buf_d = hash_in[OUT_BITS-1:0];
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    if (xfer) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // A digest arriving mid-stream is dropped; the set beats a same-cycle clear.
                    if (rise) begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        m_if.m_valid = (state_q == ST_SEND);
        m_if.m_last  = (state_q == ST_SEND) & at_last;
        m_if.m_data  = buf_q[int'(cnt_q) * DW +: DW];
        busy         = (state_q == ST_SEND);
        overrun      = ovr_q;
    end

endmodule

// File: tb/tb_keccak_digest_serializer.sv
// tb/tb_keccak_digest_serializer.sv - randomized self-checking bench with a queue-based stream model
module tb_keccak_digest_serializer;

    logic         clk = 1'b0;
    logic         rst;
    logic [511:0] hash_in, hash_in2;
    logic         hash_ready, hash_ready2;
    logic         clr_ovr, clr_ovr2;
    logic         busy, overrun, busy2, overrun2;
    logic         cmp_en;
    int           checks = 0;
    int           errors = 0;
    int           xfer_cnt = 0;

    always #5 clk = ~clk;

    keccak_digest_serializer_if #(.DW(64))  s_if ();
    keccak_digest_serializer_if #(.DW(256)) s2_if ();

    keccak_digest_serializer #(.DW(64), .OUT_BITS(512)) dut (
        .clk        (clk),
        .rst        (rst),
        .hash_in    (hash_in),
        .hash_ready (hash_ready),
        .m_if       (s_if),
        .busy       (busy),
        .overrun    (overrun),
        .clr_ovr    (clr_ovr)
    );

    keccak_digest_serializer #(.DW(256), .OUT_BITS(256)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .hash_in    (hash_in2),
        .hash_ready (hash_ready2),
        .m_if       (s2_if),
        .busy       (busy2),
        .overrun    (overrun2),
        .clr_ovr    (clr_ovr2)
    );

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected stream: every digest is a queue of words, the head is what must be on the bus.
    typedef struct {
        logic [63:0] data;
        bit          last;
    } word_t;

    word_t q[$];
    bit    m_ovr = 1'b0;
    bit    hrp   = 1'b1;

    always @(posedge clk) begin
        bit rise;
        bit xfer;
        if (rst) begin
            q.delete();
            m_ovr = 1'b0;
            hrp   = 1'b1;
        end else begin
            rise = hash_ready && !hrp;
            xfer = (q.size() > 0) && s_if.m_ready;
            if (clr_ovr) m_ovr = 1'b0;
            if (xfer) void'(q.pop_front());
            if (rise) begin
                if (q.size() == 0) begin
                    for (int k = 0; k < 8; k++) begin
                        word_t w;
                        w.data = hash_in[k*64 +: 64];
                        w.last = (k == 7);
                        q.push_back(w);
                    end
                end else begin
                    m_ovr = 1'b1;
                end
            end
            hrp = hash_ready;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cmp_valid", s_if.m_valid, q.size() > 0);
            chk("cmp_busy", busy, q.size() > 0);
            chk("cmp_last", s_if.m_last, (q.size() > 0) && q[0].last);
            if (q.size() > 0) chk("cmp_data", s_if.m_data, q[0].data);
            chk("cmp_overrun", overrun, m_ovr);
            if (s_if.m_valid && s_if.m_ready) xfer_cnt++;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [511:0] rand_digest();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        logic [511:0] d2;
        logic [3:0]   pat;
        cmp_en      = 1'b0;
        rst         = 1'b1;
        hash_in     = '0;
        hash_in2    = '0;
        hash_ready  = 1'b0;
        hash_ready2 = 1'b0;
        clr_ovr     = 1'b0;
        clr_ovr2    = 1'b0;
        s_if.m_ready  = 1'b0;
        s2_if.m_ready = 1'b1;
        step(3);
        cmp_en = 1'b1;
        chk("rst_valid", s_if.m_valid, 1'b0);
        chk("rst_data", s_if.m_data, 64'h0);
        chk("rst_last", s_if.m_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_valid2", s2_if.m_valid, 1'b0);
        chk("rst_last2", s2_if.m_last, 1'b0);
        rst = 1'b0;
        step(2);

        // Ascending byte digest, full-rate sink.
        for (int i = 0; i < 64; i++) hash_in[i*8 +: 8] = 8'(i + 1);
        s_if.m_ready = 1'b1;
        hash_ready   = 1'b1;
        step();
        hash_ready = 1'b0;
        chk("t1_model_w0", q[0].data, 64'h0807060504030201);
        chk("t1_valid", s_if.m_valid, 1'b1);
        chk("t1_w0", s_if.m_data, 64'h0807060504030201);
        chk("t1_last0", s_if.m_last, 1'b0);
        step(7);
        chk("t1_w7", s_if.m_data, 64'h403f3e3d3c3b3a39);
        chk("t1_last7", s_if.m_last, 1'b1);
        step();
        chk("t1_done", s_if.m_valid, 1'b0);

        // Stalling sink: exactly eight transfers.
        xfer_cnt   = 0;
        pat        = 4'b1001;
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            s_if.m_ready = pat[i % 4];
            step();
        end
        s_if.m_ready = 1'b1;
        step(2);
        chk("t2_xfers", 32'(xfer_cnt), 32'd8);

        // Overrun while word 3 is stalled.
        hash_in    = rand_digest();
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        step(3);
        s_if.m_ready = 1'b0;
        step();
        hash_in    = rand_digest();
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        chk("t3_overrun", overrun, 1'b1);
        s_if.m_ready = 1'b1;
        step(6);
        chk("t3_done", s_if.m_valid, 1'b0);
        chk("t3_sticky", overrun, 1'b1);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("t3_cleared", overrun, 1'b0);

        // Back-to-back digest on the final transfer.
        hash_in    = rand_digest();
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        step(7);
        d2         = rand_digest();
        hash_in    = d2;
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        chk("t4_valid", s_if.m_valid, 1'b1);
        chk("t4_w0", s_if.m_data, d2[63:0]);
        chk("t4_overrun", overrun, 1'b0);
        step(9);

        // hash_ready held high across reset, then reset mid-stream.
        rst        = 1'b1;
        hash_ready = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        chk("t5_no_stream", s_if.m_valid, 1'b0);
        hash_ready = 1'b0;
        step();
        d2         = rand_digest();
        hash_in    = d2;
        hash_ready = 1'b1;
        step();
        hash_ready = 1'b0;
        step(4);
        chk("t5_w4", s_if.m_data, d2[319:256]);
        rst = 1'b1;
        step();
        chk("t5_rst_valid", s_if.m_valid, 1'b0);
        rst = 1'b0;
        step();

        // Single-word, truncated instance.
        d2          = rand_digest();
        hash_in2    = d2;
        hash_ready2 = 1'b1;
        step();
        hash_ready2 = 1'b0;
        chk("t6_valid", s2_if.m_valid, 1'b1);
        chk("t6_data", s2_if.m_data, d2[255:0]);
        chk("t6_last", s2_if.m_last, 1'b1);
        step();
        chk("t6_done", s2_if.m_valid, 1'b0);
        chk("t6_overrun", overrun2, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            hash_in      = rand_digest();
            hash_ready   = ($urandom_range(0, 3) == 0);
            s_if.m_ready = ($urandom_range(0, 3) != 0);
            clr_ovr      = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            step();
        end
        rst     = 1'b0;
        clr_ovr = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
